// File: rtl/morse_pkg.sv
// Shared types and constants for the morse letter scheduler.
package morse_pkg;
  localparam int          LETTER_W           = 3;
  localparam int unsigned GAP_CYCLES_DEF     = 32'd75000000;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 32'd500000000;

  typedef enum logic [1:0] {IDLE, SEND, RELEASE, GAP} state_t;
endpackage

// File: rtl/morse_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first valid requester after 'last', one-hot or zero.
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [2:0]       last,
  output logic [N_REQ-1:0] grant
);
  logic [3:0]         sh;
  logic [2*N_REQ-1:0] dbl;
  logic [2*N_REQ-1:0] gdbl;
  logic [N_REQ-1:0]   rot;
  logic [N_REQ-1:0]   grot;

  // Rotate so bit 0 is (last+1), pick the lowest set bit, rotate back.
  always_comb begin
    sh   = {1'b0, last} + 4'd1;
    dbl  = {req, req} >> sh;
    rot  = dbl[N_REQ-1:0];
    grot = '0;
    for (int i = N_REQ-1; i >= 0; i--) begin
      if (rot[i]) begin
        grot    = '0;
        grot[i] = 1'b1;
      end
    end
    gdbl  = {{N_REQ{1'b0}}, grot} << sh;
    grant = gdbl[N_REQ-1:0] | gdbl[2*N_REQ-1:N_REQ];
  end
endmodule

// File: rtl/morse_scheduler.sv
// Round-robin letter scheduler feeding a single morse engine, with done timeout and inter-letter gap.
module morse_scheduler
  import morse_pkg::*;
#(
  parameter int          N_REQ          = 4,
  parameter int unsigned GAP_CYCLES     = GAP_CYCLES_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [LETTER_W*N_REQ-1:0] req_letter,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      eng_start,
  output logic [LETTER_W-1:0]       eng_letter,
  input  logic                      eng_done,
  output logic                      busy,
  output logic [2:0]                owner,
  output logic                      timeout_err
);
  state_t                state, state_nxt;
  logic [31:0]           cnt;
  logic [2:0]            last_owner, owner_q, sel_idx;
  logic [LETTER_W-1:0]   letter_q, sel_letter;
  logic [N_REQ-1:0]      grant;
  logic                  xfer, to_hit, timeout_q;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req   (req_valid),
    .last  (last_owner),
    .grant (grant)
  );

  always_comb begin
    state_nxt  = state;
    xfer       = 1'b0;
    to_hit     = 1'b0;
    req_ready  = '0;
    sel_letter = '0;
    sel_idx    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_letter = req_letter[LETTER_W*i +: LETTER_W];
        sel_idx    = 3'(i);
      end
    end
    case (state)
      IDLE: begin
        req_ready = grant;
        xfer      = |(req_valid & grant);
        if (xfer) state_nxt = SEND;
      end
      // Done has priority over a timeout landing in the same cycle.
      SEND: begin
        if (eng_done) state_nxt = RELEASE;
        else if (cnt == TIMEOUT_CYCLES - 1) begin
          to_hit    = 1'b1;
          state_nxt = RELEASE;
        end
      end
      RELEASE: state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
      GAP:     if (cnt == GAP_CYCLES - 1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      cnt        <= '0;
      last_owner <= 3'(N_REQ-1);
      owner_q    <= '0;
      letter_q   <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state     <= state_nxt;
      timeout_q <= to_hit;
      // Counter only runs in SEND/GAP so an idle block never wraps it.
      if (state_nxt != state || state_nxt == IDLE || state_nxt == RELEASE) cnt <= '0;
      else cnt <= cnt + 32'd1;
      if (xfer) begin
        letter_q   <= sel_letter;
        owner_q    <= sel_idx;
        last_owner <= sel_idx;
      end
    end
  end

  assign eng_start   = (state == SEND);
  assign busy        = (state != IDLE);
  assign owner       = owner_q;
  assign eng_letter  = letter_q;
  assign timeout_err = timeout_q;
endmodule

// File: tb/tb_morse_scheduler.sv
// Directed bench for morse_scheduler (GAP=4, TIMEOUT=20) plus a GAP=0 instance.
module tb_morse_scheduler;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [3:0]  req_valid = '0, req_ready;
  logic [11:0] req_letter = '0;
  logic        eng_start, eng_done = 1'b0, busy, timeout_err;
  logic [2:0]  eng_letter, owner;
  logic [3:0]  req_valid_z = '0, req_ready_z;
  logic [11:0] req_letter_z = '0;
  logic        eng_start_z, eng_done_z = 1'b0, busy_z, timeout_err_z;
  logic [2:0]  eng_letter_z, owner_z;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  morse_scheduler #(.N_REQ(4), .GAP_CYCLES(4), .TIMEOUT_CYCLES(20)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_letter(req_letter),
    .req_ready(req_ready), .eng_start(eng_start), .eng_letter(eng_letter),
    .eng_done(eng_done), .busy(busy), .owner(owner), .timeout_err(timeout_err));

  morse_scheduler #(.N_REQ(4), .GAP_CYCLES(0), .TIMEOUT_CYCLES(20)) dut_z (
    .clk(clk), .resetn(resetn), .req_valid(req_valid_z), .req_letter(req_letter_z),
    .req_ready(req_ready_z), .eng_start(eng_start_z), .eng_letter(eng_letter_z),
    .eng_done(eng_done_z), .busy(busy_z), .owner(owner_z), .timeout_err(timeout_err_z));

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    req_valid = '0; resetn = 1'b0; tick(); tick(); resetn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (eng_start !== 1'b0) begin bad++; $display("FAIL reset_start got=%b exp=0", eng_start); end
    total++; if (eng_letter !== 3'd0) begin bad++; $display("FAIL reset_letter got=%0d exp=0", eng_letter); end
    total++; if (owner !== 3'd0) begin bad++; $display("FAIL reset_owner got=%0d exp=0", owner); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL reset_tmo got=%b exp=0", timeout_err); end
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready_none got=%b exp=0000", req_ready); end
    req_valid = 4'b1111; #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL reset_prio got=%b exp=0001", req_ready); end
    req_valid = '0;
  endtask

  task automatic test_single();
    req_valid = 4'b0100; req_letter = {3'd0, 3'd5, 3'd0, 3'd0}; #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL single_ready got=%b exp=0100", req_ready); end
    tick(); req_valid = '0;
    total++; if (eng_start !== 1'b1) begin bad++; $display("FAIL single_start got=%b exp=1", eng_start); end
    total++; if (eng_letter !== 3'd5) begin bad++; $display("FAIL single_letter got=%0d exp=5", eng_letter); end
    total++; if (owner !== 3'd2) begin bad++; $display("FAIL single_owner got=%0d exp=2", owner); end
    repeat (9) tick();
    eng_done = 1'b1; tick(); eng_done = 1'b0;
    total++; if (eng_start !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL single_release start=%b busy=%b exp 0/1", eng_start, busy); end
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_gap%0d busy=%b exp=1", i, busy); end
    end
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle busy=%b exp=0", busy); end
    total++; if (eng_letter !== 3'd5 || owner !== 3'd2) begin bad++; $display("FAIL single_hold letter=%0d owner=%0d exp 5/2", eng_letter, owner); end
  endtask

  task automatic test_fairness();
    int seq[5] = '{0, 1, 2, 3, 0};
    do_reset();
    req_valid = 4'b1111; req_letter = {3'd4, 3'd3, 3'd2, 3'd1}; #1;
    for (int k = 0; k < 5; k++) begin
      total++; if (req_ready !== 4'(1 << seq[k])) begin bad++; $display("FAIL fair%0d_ready got=%b exp=%b", k, req_ready, 4'(1 << seq[k])); end
      tick();
      total++; if (owner !== 3'(seq[k]) || eng_letter !== 3'(seq[k] + 1)) begin bad++; $display("FAIL fair%0d_owner got=%0d/%0d exp=%0d/%0d", k, owner, eng_letter, seq[k], seq[k] + 1); end
      eng_done = 1'b1; tick(); eng_done = 1'b0;
      total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL fair%0d_release_ready got=%b exp=0000", k, req_ready); end
      repeat (5) tick();
    end
    req_valid = '0;
  endtask

  task automatic test_timeout();
    req_valid = 4'b0010; req_letter = {3'd0, 3'd0, 3'd6, 3'd0}; #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL tmo_ready got=%b exp=0010", req_ready); end
    tick(); req_valid = '0;
    for (int i = 0; i < 20; i++) begin
      total++; if (eng_start !== 1'b1 || timeout_err !== 1'b0) begin bad++; $display("FAIL tmo_send%0d start=%b err=%b exp 1/0", i, eng_start, timeout_err); end
      tick();
    end
    total++; if (timeout_err !== 1'b1 || eng_start !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL tmo_pulse err=%b start=%b busy=%b exp 1/0/1", timeout_err, eng_start, busy); end
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (timeout_err !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL tmo_gap%0d err=%b busy=%b exp 0/1", i, timeout_err, busy); end
    end
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL tmo_idle busy=%b exp=0", busy); end
  endtask

  task automatic test_collision();
    req_valid = 4'b0100; req_letter = {3'd0, 3'd7, 3'd0, 3'd0};
    tick(); req_valid = '0;
    total++; if (owner !== 3'd2 || eng_letter !== 3'd7) begin bad++; $display("FAIL coll_owner got=%0d/%0d exp=2/7", owner, eng_letter); end
    repeat (19) tick();
    eng_done = 1'b1; tick(); eng_done = 1'b0;
    total++; if (timeout_err !== 1'b0 || eng_start !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL coll_release err=%b start=%b busy=%b exp 0/0/1", timeout_err, eng_start, busy); end
    repeat (5) tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL coll_idle busy=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid();
    req_valid = 4'b1000; req_letter = {3'd3, 3'd0, 3'd0, 3'd2};
    tick(); req_valid = '0;
    total++; if (eng_start !== 1'b1 || owner !== 3'd3) begin bad++; $display("FAIL rsend_pre start=%b owner=%0d exp 1/3", eng_start, owner); end
    resetn = 1'b0; tick(); resetn = 1'b1;
    total++; if (eng_start !== 1'b0 || busy !== 1'b0 || owner !== 3'd0 || timeout_err !== 1'b0) begin bad++; $display("FAIL rsend_post start=%b busy=%b owner=%0d err=%b exp 0/0/0/0", eng_start, busy, owner, timeout_err); end
    req_valid = 4'b1001; #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rsend_prio got=%b exp=0001", req_ready); end
    tick(); req_valid = '0;
    eng_done = 1'b1; tick(); eng_done = 1'b0;
    repeat (5) tick();
    req_valid = 4'b0100; #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL rgap_ready got=%b exp=0100", req_ready); end
    tick(); req_valid = '0;
    eng_done = 1'b1; tick(); eng_done = 1'b0; tick();
    total++; if (busy !== 1'b1 || eng_start !== 1'b0) begin bad++; $display("FAIL rgap_pre busy=%b start=%b exp 1/0", busy, eng_start); end
    resetn = 1'b0; tick(); resetn = 1'b1;
    total++; if (eng_start !== 1'b0 || busy !== 1'b0 || owner !== 3'd0 || timeout_err !== 1'b0) begin bad++; $display("FAIL rgap_post start=%b busy=%b owner=%0d err=%b exp 0/0/0/0", eng_start, busy, owner, timeout_err); end
    req_valid = 4'b1001; #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rgap_prio got=%b exp=0001", req_ready); end
    req_valid = '0;
  endtask

  task automatic test_gap0();
    req_valid_z = 4'b0001; req_letter_z = {3'd0, 3'd0, 3'd0, 3'd4}; #1;
    total++; if (req_ready_z !== 4'b0001) begin bad++; $display("FAIL gap0_ready got=%b exp=0001", req_ready_z); end
    tick();
    total++; if (eng_start_z !== 1'b1 || eng_letter_z !== 3'd4) begin bad++; $display("FAIL gap0_send start=%b letter=%0d exp 1/4", eng_start_z, eng_letter_z); end
    eng_done_z = 1'b1; tick(); eng_done_z = 1'b0;
    total++; if (req_ready_z !== 4'b0000 || busy_z !== 1'b1) begin bad++; $display("FAIL gap0_release ready=%b busy=%b exp 0000/1", req_ready_z, busy_z); end
    tick();
    total++; if (req_ready_z !== 4'b0001 || busy_z !== 1'b0) begin bad++; $display("FAIL gap0_rearm ready=%b busy=%b exp 0001/0", req_ready_z, busy_z); end
    req_valid_z = '0; eng_done_z = 1'b1; tick(); eng_done_z = 1'b0;
    total++; if (busy_z !== 1'b0 || eng_start_z !== 1'b0 || owner_z !== 3'd0) begin bad++; $display("FAIL gap0_spurious busy=%b start=%b owner=%0d exp 0/0/0", busy_z, eng_start_z, owner_z); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_timeout();
    test_collision();
    test_reset_mid();
    test_gap0();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
